// File: rtl/gsim_ctrl.sv
// gsim_ctrl: sequencing controller for a Gauss-Seidel solver.
// The block loads a 16-element b vector. It then runs ITER sweeps of row
// updates through an external shared update unit, using a req/ack handshake.
// Finally it streams the 16-element x result back out.
// Optional feature: define GSIM_EARLY_EXIT_EN to add the upd_small input.
// With that feature, a sweep in which every update was small ends the solve early.
module gsim_ctrl #(
  parameter int ITER = 64,
  parameter int N    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_en,
  input  logic signed [15:0] b_in,
  output logic               upd_req,
  output logic [3:0]         upd_idx,
  output logic signed [15:0] upd_b,
  input  logic               upd_ack,
`ifdef GSIM_EARLY_EXIT_EN
  input  logic               upd_small,
`endif
  output logic               x_clr,
  output logic [3:0]         rd_idx,
  input  logic signed [31:0] rd_x,
  output logic               out_valid,
  output logic signed [31:0] x_out,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SWEEP = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'(N - 1);
  localparam logic [4:0] OUT_WORDS  = 5'(N);
  localparam logic [7:0] SWEEP_LAST = 8'(ITER - 1);

  state_t             state_q, state_d;
  logic [3:0]         load_cnt_q, load_cnt_d;
  logic [7:0]         sweep_q, sweep_d;
  logic [3:0]         upd_idx_q, upd_idx_d;
  logic               upd_req_q, upd_req_d;
  logic               x_clr_q, x_clr_d;
  logic [3:0]         rd_idx_q, rd_idx_d;
  logic [4:0]         out_cnt_q, out_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic signed [31:0] x_out_q, x_out_d;
  logic               busy_q, busy_d;
  logic               exit_now;
  logic               b_we;
  logic [3:0]         b_waddr;
  logic signed [15:0] upd_b_q;
`ifdef GSIM_EARLY_EXIT_EN
  logic               all_small_q, all_small_d;
`endif

  // b storage is never reset; every solve rewrites all N entries before use.
  logic signed [15:0] b_mem [N];

  // Next-state and next-output logic for the whole controller.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    sweep_d     = sweep_q;
    upd_idx_d   = upd_idx_q;
    upd_req_d   = upd_req_q;
    x_clr_d     = 1'b0;
    rd_idx_d    = rd_idx_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = 1'b0;
    x_out_d     = x_out_q;
    b_we        = 1'b0;
    b_waddr     = load_cnt_q;
`ifdef GSIM_EARLY_EXIT_EN
    all_small_d = all_small_q;
    // The ack of the last row also counts toward the all-small test.
    exit_now    = (sweep_q == SWEEP_LAST) || (all_small_q && upd_small);
`else
    exit_now    = (sweep_q == SWEEP_LAST);
`endif

    case (state_q)
      IDLE: begin
        if (in_en) begin
          b_we       = 1'b1;
          b_waddr    = 4'd0;
          load_cnt_d = 4'd1;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        if (in_en) begin
          b_we = 1'b1;
          if (load_cnt_q == LAST_IDX) begin
            // The x_clr cycle runs with upd_req still low.
            // This lets the update unit clear x before the first row request.
            load_cnt_d = 4'd0;
            x_clr_d    = 1'b1;
            upd_idx_d  = 4'd0;
            sweep_d    = 8'd0;
            upd_req_d  = 1'b0;
            state_d    = SWEEP;
          end else begin
            load_cnt_d = load_cnt_q + 4'd1;
          end
        end
      end

      SWEEP: begin
        if (!upd_req_q) begin
          upd_req_d = 1'b1;
`ifdef GSIM_EARLY_EXIT_EN
          all_small_d = 1'b1;
`endif
        end else if (upd_ack) begin
          if (upd_idx_q == LAST_IDX) begin
            upd_idx_d = 4'd0;
            if (exit_now) begin
              upd_req_d = 1'b0;
              sweep_d   = 8'd0;
              rd_idx_d  = 4'd0;
              out_cnt_d = 5'd0;
              state_d   = OUT;
            end else begin
              sweep_d = sweep_q + 8'd1;
`ifdef GSIM_EARLY_EXIT_EN
              all_small_d = 1'b1;
`endif
            end
          end else begin
            upd_idx_d = upd_idx_q + 4'd1;
`ifdef GSIM_EARLY_EXIT_EN
            all_small_d = all_small_q && upd_small;
`endif
          end
        end
      end

      OUT: begin
        // The state stays in OUT through the cycle that shows the last
        // out_valid, so DONE follows that cycle instead of overlapping it.
        if (out_cnt_q != OUT_WORDS) begin
          x_out_d     = rd_x;
          out_valid_d = 1'b1;
          rd_idx_d    = rd_idx_q + 4'd1;
          out_cnt_d   = out_cnt_q + 5'd1;
        end else begin
          rd_idx_d  = 4'd0;
          out_cnt_d = 5'd0;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Control state and registered outputs; asynchronous reset clears them from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      load_cnt_q  <= 4'd0;
      sweep_q     <= 8'd0;
      upd_idx_q   <= 4'd0;
      upd_req_q   <= 1'b0;
      x_clr_q     <= 1'b0;
      rd_idx_q    <= 4'd0;
      out_cnt_q   <= 5'd0;
      out_valid_q <= 1'b0;
      x_out_q     <= 32'sd0;
      busy_q      <= 1'b0;
`ifdef GSIM_EARLY_EXIT_EN
      all_small_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      sweep_q     <= sweep_d;
      upd_idx_q   <= upd_idx_d;
      upd_req_q   <= upd_req_d;
      x_clr_q     <= x_clr_d;
      rd_idx_q    <= rd_idx_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
      busy_q      <= busy_d;
`ifdef GSIM_EARLY_EXIT_EN
      all_small_q <= all_small_d;
`endif
    end
  end

  // b write port, plus a registered read that is addressed by the next row index.
  // As a result, upd_b lines up with upd_idx on the same cycle.
  always_ff @(posedge clk) begin
    if (b_we) begin
      b_mem[b_waddr] <= b_in;
    end
    upd_b_q <= b_mem[upd_idx_d];
  end

  assign upd_req   = upd_req_q;
  assign upd_idx   = upd_idx_q;
  assign upd_b     = upd_b_q;
  assign x_clr     = x_clr_q;
  assign rd_idx    = rd_idx_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gsim_ctrl.sv
// Testbench for gsim_ctrl.
// It includes a behavioural update unit in which each ack adds b<<16 into x[idx], and x_clr zeroes x.
// The bench uses scoreboard queues of expected (idx, b) updates and of expected x_out words.
// Those queues are filled when the b vector is driven.
module tb_gsim_ctrl;
`ifdef GSIM_EARLY_EXIT_EN
  localparam int ITER_P = 64;
`else
  localparam int ITER_P = 2;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_en = 1'b0;
  logic signed [15:0] b_in = '0;
  logic               upd_req;
  logic [3:0]         upd_idx;
  logic signed [15:0] upd_b;
  logic               upd_ack = 1'b0;
  logic               upd_small = 1'b0;
  logic               x_clr;
  logic [3:0]         rd_idx;
  logic signed [31:0] rd_x;
  logic               out_valid;
  logic signed [31:0] x_out;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_mode = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] b;
  } upd_t;
  upd_t        upd_q[$];
  logic [31:0] out_q[$];
  logic [31:0] x_mem [16];

  gsim_ctrl #(.ITER(ITER_P), .N(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .b_in      (b_in),
    .upd_req   (upd_req),
    .upd_idx   (upd_idx),
    .upd_b     (upd_b),
    .upd_ack   (upd_ack),
`ifdef GSIM_EARLY_EXIT_EN
    .upd_small (upd_small),
`endif
    .x_clr     (x_clr),
    .rd_idx    (rd_idx),
    .rd_x      (rd_x),
    .out_valid (out_valid),
    .x_out     (x_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared update unit.
  always @(posedge clk) begin
    if (x_clr) begin
      for (int i = 0; i < 16; i++) x_mem[i] <= 32'h0;
    end else if (upd_req && upd_ack) begin
      x_mem[upd_idx] <= x_mem[upd_idx] + {upd_b, 16'h0};
    end
  end

  assign rd_x = (rd_mode != 0) ? {12'h0, rd_idx, 16'h0} : x_mem[rd_idx];

  // Checks every output that reset must clear.
  task automatic check_zero_outputs(input string tag);
    checks++; if (upd_req !== 1'b0) begin errors++; $display("FAIL %s upd_req got %b want 0", tag, upd_req); end
    checks++; if (upd_idx !== 4'd0) begin errors++; $display("FAIL %s upd_idx got %0d want 0", tag, upd_idx); end
    checks++; if (rd_idx !== 4'd0) begin errors++; $display("FAIL %s rd_idx got %0d want 0", tag, rd_idx); end
    checks++; if (x_clr !== 1'b0) begin errors++; $display("FAIL %s x_clr got %b want 0", tag, x_clr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid got %b want 0", tag, out_valid); end
    checks++; if (x_out !== 32'h0) begin errors++; $display("FAIL %s x_out got %h want 0", tag, x_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", tag, busy); end
  endtask

  // One complete solve. Inputs are driven at negedge, and outputs are sampled at negedge.
  // pat: 0 -> b = 1..16, 1 -> random. A gap of gap_len idle cycles is inserted before b[gap_after+1].
  // abort_acks > 0 applies an asynchronous reset once that many acks have been accepted.
  task automatic run_solve(input string name, input int pat, input int gap_after, input int gap_len,
                           input int ack_period, input int mode, input int n_sweeps,
                           input int small_from, input int abort_acks);
    logic [15:0] bv [16];
    logic [31:0] tmp;
    int load_cyc, last_ack, last_ov, acks, clr_cnt, budget, outs;
    bit ack_nx, done, seen_req, seen_ov;
    load_cyc = 0; last_ack = 0; last_ov = 0; acks = 0; clr_cnt = 0; outs = 0;
    done = 0; seen_req = 0; seen_ov = 0;
    rd_mode = mode;
    upd_q.delete();
    out_q.delete();
    for (int i = 0; i < 16; i++) bv[i] = (pat == 0) ? 16'(i + 1) : 16'($urandom);
    for (int s = 0; s < n_sweeps; s++)
      for (int i = 0; i < 16; i++) upd_q.push_back('{4'(i), bv[i]});
    for (int i = 0; i < 16; i++) begin
      tmp = {bv[i], 16'h0};
      out_q.push_back((mode != 0) ? {12'h0, 4'(i), 16'h0} : 32'(tmp * 32'(n_sweeps)));
    end

    // Load phase.
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_after + 1) begin
        for (int g = 0; g < gap_len; g++) begin
          in_en = 1'b0;
          b_in = 16'($urandom);
          @(negedge clk);
        end
      end
      in_en = 1'b1;
      b_in = bv[i];
      load_cyc = cyc;
      @(negedge clk);
    end
    in_en = 1'b0;

    // Sweep and output phases, with a bounded number of cycles.
    budget = 16 * n_sweeps * (ack_period + 1) + 200;
    for (int k = 0; k < budget && !done; k++) begin
      if (k > 0) @(negedge clk);
      in_en = 1'b0;
      if (x_clr) clr_cnt++;
      if (upd_req && !seen_req) begin
        seen_req = 1;
        checks++;
        if (cyc - load_cyc != 2) begin
          errors++; $display("FAIL %s req_latency got %0d want 2", name, cyc - load_cyc);
        end
      end
      if (abort_acks > 0 && acks == abort_acks) begin
        upd_ack = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero_outputs({name, "_async_reset"});
        @(negedge clk);
        reset = 1'b0;
        $display("%s: aborted by reset after %0d acks", name, acks);
        return;
      end
      ack_nx = (ack_period <= 1) ? 1'b1 : ((cyc % ack_period) == 0);
      upd_ack = ack_nx;
      upd_small = (small_from >= 0) && (acks >= 16 * small_from);
      if (upd_req) begin
        in_en = 1'($urandom);
        b_in = 16'($urandom);
        checks++;
        if (upd_q.size() == 0) begin
          errors++; $display("FAIL %s extra_req idx got %0d want none", name, upd_idx);
        end else begin
          if (upd_idx !== upd_q[0].idx) begin
            errors++; $display("FAIL %s upd_idx got %0d want %0d", name, upd_idx, upd_q[0].idx);
          end
          checks++;
          if (upd_b !== upd_q[0].b) begin
            errors++; $display("FAIL %s upd_b got %h want %h", name, upd_b, upd_q[0].b);
          end
          if (ack_nx) begin
            void'(upd_q.pop_front());
            acks++;
            last_ack = cyc;
          end
        end
      end
      if (out_valid) begin
        if (!seen_ov) begin
          seen_ov = 1;
          checks++;
          if (cyc - last_ack != 2) begin
            errors++; $display("FAIL %s out_latency got %0d want 2", name, cyc - last_ack);
          end
        end
        checks++;
        if (out_q.size() == 0) begin
          errors++; $display("FAIL %s extra_out x_out got %h want none", name, x_out);
        end else begin
          if (x_out !== out_q[0]) begin
            errors++; $display("FAIL %s x_out[%0d] got %h want %h", name, outs, x_out, out_q[0]);
          end
          void'(out_q.pop_front());
        end
        outs++;
        last_ov = cyc;
      end else if (seen_ov && !busy) begin
        checks++;
        if (cyc - last_ov != 2) begin
          errors++; $display("FAIL %s busy_drop got %0d want 2", name, cyc - last_ov);
        end
        done = 1;
      end
    end
    upd_ack = 1'b0;
    upd_small = 1'b0;
    in_en = 1'b0;

    checks++; if (!done) begin errors++; $display("FAIL %s timeout done got 0 want 1", name); end
    checks++; if (clr_cnt != 1) begin errors++; $display("FAIL %s x_clr_pulses got %0d want 1", name, clr_cnt); end
    checks++; if (acks != 16 * n_sweeps) begin errors++; $display("FAIL %s acks got %0d want %0d", name, acks, 16 * n_sweeps); end
    checks++; if (outs != 16) begin errors++; $display("FAIL %s out_count got %0d want 16", name, outs); end
    checks++; if (upd_q.size() != 0 || out_q.size() != 0) begin
      errors++; $display("FAIL %s leftover got %0d/%0d want 0/0", name, upd_q.size(), out_q.size());
    end
    $display("%s: acks=%0d outs=%0d x_clr=%0d", name, acks, outs, clr_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("post_reset_idle");
    $display("test_reset: done");
  endtask

  task automatic test_contiguous();
    run_solve("contiguous", 0, 99, 0, 1, 0, ITER_P, -1, 0);
  endtask

  task automatic test_load_gap();
    run_solve("load_gap", 1, 5, 3, 1, 0, ITER_P, -1, 0);
  endtask

  task automatic test_ack_every_3rd();
    run_solve("ack_every_3rd", 1, 99, 0, 3, 0, ITER_P, -1, 0);
  endtask

  task automatic test_out_ramp();
    run_solve("out_ramp", 1, 99, 0, 1, 1, ITER_P, -1, 0);
  endtask

  task automatic test_reset_mid();
    run_solve("reset_mid_sweep", 1, 99, 0, 1, 0, ITER_P, -1, 23);
    run_solve("after_reset", 1, 99, 0, 2, 0, ITER_P, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_solve("back_to_back_a", 0, 99, 0, 1, 0, ITER_P, -1, 0);
    run_solve("back_to_back_b", 1, 99, 0, 1, 0, ITER_P, -1, 0);
  endtask

`ifdef GSIM_EARLY_EXIT_EN
  task automatic test_early_exit();
    run_solve("early_exit", 1, 99, 0, 1, 0, 4, 3, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_contiguous();
    test_load_gap();
    test_ack_every_3rd();
    test_out_ramp();
    test_reset_mid();
    test_back_to_back();
`ifdef GSIM_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
